sram_like_responder: RTL
========================

Name: sram_like_responder

Overview:
- Responder (slave) end of the SoC's sram-like request protocol (req/wr/size/addr/wdata -> addr_ok/data_ok/rdata).
- Backs one sram-like channel with an internal word-organised memory and programmable response latency.
- Serves as the inst or data endpoint for the CPU-side sram-like master.
- Used as the on-chip scratch RAM and as the behavioural target for interface verification.

Parameters:
- ADDR_W, 10: word-index width; memory holds 2**ADDR_W 32-bit words.
- RESP_LAT, 2: cycles from address handshake to data_ok; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  transfer size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 4 bytes.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; upper bits ignored.
- wdata  in  32  write data, byte-lane aligned (lane = addr[1:0]).
- rdata  out  32  read data, full word, valid while data_ok = 1.
- addr_ok  out  1  address/write-data accepted (combinational).
- data_ok  out  1  response strobe: read data valid, or write complete.

Behaviour:
- Reset (resetn = 0 at a rising edge):
  - state <= IDLE; data_ok <= 0; rdata <= 0; counter <= 0.
  - addr_ok is forced to 0 while resetn = 0.
  - Memory contents are not cleared.
- States: IDLE, BUSY, RESP.
- addr_ok:
  - equals req in IDLE; 0 in BUSY.
  - 0 in RESP unless SRAM_RESP_B2B_EN is defined (see Optional Feature).
- Handshake: occurs in cycle T when req & addr_ok. At that edge, capture wr, size, addr[1:0] and the word index.
- Writes commit to memory at the handshake edge, with byte enables:
  - size 0: one lane, selected by addr[1:0].
  - size 1: lanes {addr[1],0} and {addr[1],1}.
  - size 2/3: all four lanes.
- Misaligned writes are accepted and answered normally, but no memory update occurs. Misaligned means size 1 with addr[0] = 1, or size 2/3 with addr[1:0] != 0.
- Transitions:
  - IDLE -> RESP at the handshake when RESP_LAT = 1.
  - IDLE -> BUSY (counter <= RESP_LAT-2) at the handshake when RESP_LAT > 1.
  - BUSY: if counter = 0, go to RESP; otherwise decrement the counter.
  - RESP lasts exactly one cycle, then returns to IDLE.
- Latency: data_ok is high in cycle T+RESP_LAT, for exactly one cycle per accepted request.
- rdata:
  - Loaded on entry to RESP with the full memory word at the captured index (reads only).
  - Writes leave rdata unchanged.
  - rdata holds its value after data_ok drops.
- Ordering: strictly one outstanding request; responses are in order.
- Read-after-write: a read accepted any cycle after a write's handshake observes the written data.
- req while not accepting: no effect; the master must hold req/addr/wr/size/wdata stable until addr_ok.
- Reset mid-operation: the pending response is dropped (no data_ok). A write already accepted stays committed.
- Back-to-back without the feature: handshakes are at least RESP_LAT+1 cycles apart.

Optional Feature:
- Macro: SRAM_RESP_B2B_EN.
- Defined: in RESP, addr_ok = req.
  - A handshake in RESP goes directly to BUSY/RESP, per the same rules as from IDLE.
  - data_ok stays high for consecutive RESP cycles when RESP_LAT = 1.
  - Sustained throughput is one request per RESP_LAT cycles.
- Undefined: RESP always returns to IDLE first; addr_ok = 0 in RESP.

Decomposition:
- Shared package sram_like_pkg:
  - state encoding (IDLE/BUSY/RESP);
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - RESP_LAT legal-range constants.
- Sub-module sram_like_be_gen: combinational size + addr[1:0] -> 4-bit byte enable plus misalign flag. Reusable by the master-side interface.

Test Plan:
- Single read, RESP_LAT = 2, preloaded word 0x1234_5678 at addr 0x0000_0010; req held from cycle 0 -> addr_ok in cycle 0, data_ok only in cycle 2, rdata = 0x1234_5678.
- Byte write size 0, addr 0x0000_0021, wdata 0x0000_AB00 over word 0xFFFF_FFFF, then word read of 0x20 -> rdata = 0xFFFF_ABFF.
- Half write size 1, addr 0x22, wdata 0xBEEF_0000, then misaligned half write to addr 0x23 -> first gives word 0xBEEF_xxxx; second gets addr_ok and data_ok but the memory word is unchanged.
- req held high continuously, RESP_LAT = 3, without the macro -> handshakes at cycles 0, 4, 8; data_ok at 3, 7, 11. With SRAM_RESP_B2B_EN -> handshakes at 0, 3, 6; data_ok at 3, 6, 9.
- resetn low for one cycle in BUSY after a write to addr 0x40 of 0xCAFE_F00D -> no data_ok, state IDLE, rdata = 0; a subsequent read of 0x40 returns 0xCAFE_F00D.
- RESP_LAT = 1 read/write alternation at addr 0x80 (write 0x0000_0001, then read) -> data_ok the cycle after each handshake; the read returns 0x0000_0001.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like request protocol: FSM state codes,
// transfer-size codes and the legal response-latency range.
package sram_like_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int RESP_LAT_MIN = 1;
  localparam int RESP_LAT_MAX = 15;

  function automatic bit resp_lat_legal(input int lat);
    return (lat >= RESP_LAT_MIN) && (lat <= RESP_LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// One sram-like channel.
// Handshake: an address phase completes in the cycle where req & addr_ok are
// both high; the master holds req/wr/size/addr/wdata stable until then.
// data_ok is a one-cycle response strobe with rdata valid alongside it.
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_be_gen.sv
// Byte-enable and misalignment decode for an sram-like transfer
// from its size code and the low two address bits.
module sram_like_be_gen
  import sram_like_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] lane,
  output logic [3:0] be,
  output logic       misalign
);

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        misalign = lane[0];
      end
      default: begin
        // Size 3 is treated exactly like a full word.
        be       = 4'b1111;
        misalign = |lane;
      end
    endcase
  end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of an sram-like channel backed by a word-organised RAM with
// a fixed response latency. Define SRAM_RESP_B2B_EN to accept a new request
// in the response cycle.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RESP_LAT = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_like_responder_if.slave bus,
  output logic [1:0]           state_dbg
);

  if (!resp_lat_legal(RESP_LAT)) begin : g_bad_lat
    $error("sram_like_responder: RESP_LAT out of range");
  end

  logic [31:0]       mem [2**ADDR_W];
  logic [1:0]        state;
  logic [3:0]        counter;
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic              cap_wr;
  logic [ADDR_W-1:0] cap_idx;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        be;
  logic              misalign;
  logic              addr_ok;
  logic              hs;

  sram_like_be_gen u_be_gen (
    .size     (bus.size),
    .lane     (bus.addr[1:0]),
    .be       (be),
    .misalign (misalign)
  );

  assign idx          = bus.addr[ADDR_W+1:2];
  assign hs           = bus.req & addr_ok;
  assign bus.addr_ok  = addr_ok;
  assign bus.data_ok  = data_ok_q;
  assign bus.rdata    = rdata_q;
  assign state_dbg    = state;

  always_comb begin
    addr_ok = 1'b0;
    if (resetn) begin
      case (state)
        ST_IDLE: addr_ok = bus.req;
`ifdef SRAM_RESP_B2B_EN
        ST_RESP: addr_ok = bus.req;
`endif
        default: addr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      counter   <= '0;
    end else begin
      data_ok_q <= 1'b0;
      case (state)
        ST_BUSY: begin
          if (counter == '0) begin
            state     <= ST_RESP;
            data_ok_q <= 1'b1;
            if (!cap_wr) rdata_q <= mem[cap_idx];
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: begin
          // IDLE and RESP share the launch path; without the B2B option hs is 0 in RESP.
          state <= ST_IDLE;
          if (hs) begin
            if (RESP_LAT == 1) begin
              state     <= ST_RESP;
              data_ok_q <= 1'b1;
              if (!bus.wr) rdata_q <= mem[idx];
            end else begin
              state   <= ST_BUSY;
              counter <= 4'(RESP_LAT - 2);
            end
          end
        end
      endcase
    end
  end

  // Writes commit at the handshake edge, so a reset afterwards cannot undo them.
  always_ff @(posedge clk) begin
    if (hs) begin
      cap_wr  <= bus.wr;
      cap_idx <= idx;
    end
    if (hs && bus.wr && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

endmodule
